multi_timer: RTL
================

Name: multi_timer

Overview:
Parametrised multi-channel countdown timer, successor to the single 16-bit one-shot timer. It provides NUM_CH independent channels of WIDTH bits, each running in one-shot or periodic mode. All channels share one runtime-programmable prescaler, and each channel has pause/stop control, an expiry pulse and a count readback mux. It sits beside the control FSMs that need timeouts and periodic ticks, and replaces per-FSM ad-hoc counters.

Parameters:
NUM_CH, 4, number of independent timer channels (1..16)
WIDTH, 16, counter and reload width in bits (2..32)
PRE_W, 8, prescaler compare width; one tick = prescale+1 clocks

Ports:
clk  input  1  single clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
prescale  input  PRE_W  tick period minus one, shared by all channels; 0 = tick every clock
load  input  NUM_CH  per-channel load strobe
cycles  input  NUM_CH*WIDTH  per-channel load value; channel i uses bits [i*WIDTH +: WIDTH]
periodic  input  NUM_CH  per-channel mode, sampled with load: 1 = auto-reload, 0 = one-shot
pause  input  NUM_CH  per-channel hold; counter frozen while high
stop  input  NUM_CH  per-channel cancel strobe
busy  output  NUM_CH  channel counter non-zero
expired  output  NUM_CH  one-clock pulse when a channel count reaches terminal
rd_sel  input  $clog2(NUM_CH) (min 1)  channel select for readback
rd_count  output  WIDTH  combinational current counter of channel rd_sel; 0 if rd_sel >= NUM_CH

Behaviour:
- Fixed: one clock; reset is synchronous and active-low.
- Reset (reset_n=0 at an edge): all counters, reload registers, mode bits and the prescaler go to 0. busy=0 and expired=0 from the next cycle. Reset mid-count aborts with no expired pulse.
- Prescaler: free-running pre_cnt, independent of channel activity.
  - tick=1 when pre_cnt >= prescale; then pre_cnt<=0, else pre_cnt+1.
  - The >= comparison keeps the prescaler safe when prescale is lowered mid-count.
  - prescale=0 gives tick on every clock.
- Per-channel priority at each edge: reset > load > stop > count.
  - load: counter<=cycles, reload<=cycles, mode<=periodic[i]. Clears any pending expire. No expired pulse, even if the channel was busy (restart).
  - load with cycles=0: counter=0, busy low, no expired pulse, channel idle.
  - stop: counter<=0, no expired pulse.
  - count: if tick && !pause[i] && counter!=0, then:
    - counter>1: counter-1.
    - counter==1, one-shot: counter<=0, expired<=1.
    - counter==1, periodic: counter<=reload, expired<=1, busy stays high.
- expired is registered. It is high for exactly one clock, in the same cycle the counter first shows 0 (one-shot) or the reload value (periodic). Otherwise it is 0.
- busy = (counter != 0), combinational from the register.
- Latency with prescale=0: load at edge E gives busy high for exactly cycles clocks, and expired high in cycle E+cycles.
- Latency with prescale=P: first decrement occurs within 1..P+1 clocks of the load. Load to expiry is in [(cycles-1)(P+1)+1, cycles(P+1)] clocks.
- pause on a tick cycle skips that decrement; it is not deferred. pause does not affect load or stop.
- Periodic with reload=1: expired pulses on every tick and busy stays high.
- No arithmetic wrap: decrement only occurs from a non-zero value; WIDTH-bit values only.
- Channels are fully independent; simultaneous events on different channels do not interact.

Test Plan:
- Reset then one-shot: prescale=0, load ch0 cycles=5 -> busy[0] high 5 clocks, expired[0] single pulse in the first cycle busy[0]=0; rd_count shows 5,4,3,2,1,0.
- Periodic: prescale=0, ch1 cycles=3, periodic=1 -> expired[1] pulses every 3 clocks for ≥4 periods; busy[1] never drops; stop[1] -> busy[1]=0 next cycle, no expired pulse.
- Prescaler: prescale=3, ch2 cycles=2 -> expiry 5..8 clocks after load; pause[2] held for 8 clocks mid-count -> expiry delayed by exactly 2 ticks (8 clocks).
- Boundaries: load cycles=0 -> busy low, no expired; reload ch0 with 4 while at counter=1 on a tick -> no expired, count restarts at 4; load and stop in the same cycle -> load wins.
- Reset mid-operation: all channels counting, reset_n=0 for 1 clock -> all busy=0, expired=0, rd_count=0, no pulse afterwards until a new load.
- Concurrency: all NUM_CH channels loaded the same cycle with cycles=1..NUM_CH -> expired[i] fires at clock i+1 after load, one channel per clock.

Source files
------------

// File: rtl/multi_timer.sv
// Multi-channel countdown timer. NUM_CH independent one-shot/periodic channels
// share one runtime-programmable prescaler and one combinational count readback mux.
module multi_timer #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  parameter int PRE_W  = 8,
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PRE_W-1:0]        prescale,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] cycles,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH-1:0]       pause,
  input  logic [NUM_CH-1:0]       stop,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       expired,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [WIDTH-1:0]        rd_count
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic [PRE_W-1:0]  r_pre_cnt;
  logic              w_tick;
  logic [WIDTH-1:0]  r_count      [NUM_CH];
  logic [WIDTH-1:0]  r_reload     [NUM_CH];
  logic [WIDTH-1:0]  w_count_nxt  [NUM_CH];
  logic [WIDTH-1:0]  w_reload_nxt [NUM_CH];
  logic [NUM_CH-1:0] r_mode;
  logic [NUM_CH-1:0] w_mode_nxt;
  logic [NUM_CH-1:0] r_expired;
  logic [NUM_CH-1:0] w_expired_nxt;

  // Tick decode; >= keeps the prescaler from running away if prescale drops mid-count
  always_comb begin
    w_tick = (r_pre_cnt >= prescale);
  end

  // Free-running prescaler counter, shared by every channel
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
    end else begin
      r_pre_cnt <= r_pre_cnt + PRE_W'(1);
    end
  end

  // Per-channel next state: load beats stop, stop beats counting
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_count_nxt[i]   = r_count[i];
      w_reload_nxt[i]  = r_reload[i];
      w_mode_nxt[i]    = r_mode[i];
      w_expired_nxt[i] = 1'b0;
      if (load[i]) begin
        w_count_nxt[i]  = cycles[i*WIDTH +: WIDTH];
        w_reload_nxt[i] = cycles[i*WIDTH +: WIDTH];
        w_mode_nxt[i]   = periodic[i];
      end else if (stop[i]) begin
        w_count_nxt[i] = '0;
      end else if (w_tick && !pause[i] && (r_count[i] != '0)) begin
        if (r_count[i] == C_ONE) begin
          w_expired_nxt[i] = 1'b1;
          if (r_mode[i]) begin
            w_count_nxt[i] = r_reload[i];
          end else begin
            w_count_nxt[i] = '0;
          end
        end else begin
          w_count_nxt[i] = r_count[i] - C_ONE;
        end
      end else begin
        w_count_nxt[i] = r_count[i];
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_count[i]  <= '0;
        r_reload[i] <= '0;
      end
      r_mode    <= '0;
      r_expired <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_count[i]  <= w_count_nxt[i];
        r_reload[i] <= w_reload_nxt[i];
      end
      r_mode    <= w_mode_nxt;
      r_expired <= w_expired_nxt;
    end
  end

  // Status outputs straight from the channel registers
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (r_count[i] != '0);
    end
    expired = r_expired;
  end

  // Readback mux; unpopulated selects read as zero
  always_comb begin
    rd_count = '0;
    if (int'(rd_sel) < NUM_CH) begin
      rd_count = r_count[rd_sel];
    end else begin
      rd_count = '0;
    end
  end

endmodule
